osd_overlay: RTL and testbench
==============================

OSD_OVERLAY -- requirements
Module: osd_overlay

Interface
REQ-001 Parameter OSD_X1, default 96: first OSD pixel column in active-pixel units.
REQ-002 Parameter OSD_Y1, default 80: first OSD line in active-line units.
REQ-003 Parameter COLS, default 16: text columns.
REQ-004 Parameter ROWS, default 4: text rows; COLS*ROWS SHALL be 64.
REQ-005 CLK_i  in  1  master clock (21.477 MHz NTSC / 21.281 MHz PAL).
REQ-006 NRST_i  in  1  reset; asynchronous, active-low.
REQ-007 PIXEL_EN_i  in  1  pixel strobe, one CLK_i cycle in every 4.
REQ-008 HBLANK_i  in  1  PPU horizontal blank; 1 = blank.
REQ-009 VBLANK_i  in  1  PPU vertical blank; 1 = blank.
REQ-010 OSD_EN_i  in  1  1 = overlay visible.
REQ-011 RGB_i  in  15  PPU test-mode colour, {B[14:10], G[9:5], R[4:0]}.
REQ-012 BRIGHTNESS_i  in  4  INIDISP brightness, 0..15.
REQ-013 CHAR_WE_i  in  1  character buffer write strobe.
REQ-014 CHAR_WADDR_i  in  6  buffer address = row*COLS + col.
REQ-015 CHAR_WDATA_i  in  7  character code.
REQ-016 FONT_ADDR_o  out  11  font ROM address = {code[6:0], glyph_line[3:0]}.
REQ-017 FONT_DATA_i  in  8  font ROM row; registered ROM, 1-cycle latency; bit 7 = leftmost pixel.
REQ-018 RDIG_o, GDIG_o, BDIG_o  out  9 each  DAC colour.

Function
REQ-019 h_cnt (9 b): held 0 while HBLANK_i=1; else +1 on each PIXEL_EN_i; saturates at 511.
REQ-020 v_cnt (9 b): held 0 while VBLANK_i=1; else +1 on the cycle after a registered HBLANK_i 0->1 edge; saturates at 511.
REQ-021 Window active iff OSD_X1 <= h_cnt < OSD_X1+COLS*8 and OSD_Y1 <= v_cnt < OSD_Y1+ROWS*12.
REQ-022 glyph_line (4 b) and text_row (2 b): zero when v_cnt < OSD_Y1; on each v_cnt increment inside the vertical window, glyph_line +1, wrapping 11->0 with text_row +1; no divider.
REQ-023 text_col = (h_cnt-OSD_X1)>>3; pixel bit index = 7-(h_cnt-OSD_X1)[2:0].
REQ-024 Character buffer: 64 x 7-bit registers; write on CHAR_WE_i at any time, including active video.
REQ-025 Read and write of the same address in one cycle returns the old code; the new code is visible the following cycle.
REQ-026 Pipeline: stage 1 = counters/window decode; stage 2 = buffer read, FONT_ADDR_o registered; stage 3 = FONT_DATA_i bit select plus mix, outputs registered.
REQ-027 Output latency from RGB_i/HBLANK_i/VBLANK_i to RDIG_o/GDIG_o/BDIG_o is exactly 3 CLK_i cycles; RGB, blank and window flags are delayed to align.
REQ-028 Pipeline advances every CLK_i cycle; PIXEL_EN_i gates only h_cnt.
REQ-029 Mix when the delayed HBLANK or VBLANK = 1: all outputs 0.
REQ-030 Mix outside the window or with OSD_EN_i=0: channel_o = channel_i * BRIGHTNESS_i (9-bit unsigned, max 31*15 = 465).
REQ-031 Mix inside the window with font bit = 1: all channels 465.
REQ-032 Mix inside the window with font bit = 0: channel_o = (channel_i>>1) * BRIGHTNESS_i (dimmed backdrop).
REQ-033 BRIGHTNESS_i is sampled in stage 3; no latency compensation.
REQ-034 OSD_EN_i is sampled once per frame on the VBLANK_i 0->1 edge; mid-frame changes take effect the next frame.

Reset
REQ-035 NRST_i=0 asynchronously clears h_cnt, v_cnt, glyph_line, text_row, all pipeline registers, FONT_ADDR_o, RDIG_o/GDIG_o/BDIG_o and the latched OSD_EN to 0.
REQ-036 Reset loads every character buffer entry with 0x20 (space).
REQ-037 After reset release, outputs stay 0 until the first pixel reaches stage 3; the first frame after a mid-frame reset renders from v_cnt=0 with no partial-glyph artefact beyond that frame.

Verification
REQ-038 OSD_EN_i=0, RGB_i=0x7FFF, BRIGHTNESS_i=15, active video -> all outputs 465 three cycles later.
REQ-039 RGB_i R=31, BRIGHTNESS_i=8 inside the window, space glyph (FONT_DATA_i=0) -> RDIG_o=15*8=120.
REQ-040 Write code 0x41 at address 17; model ROM returns 0x80 -> at v_cnt=OSD_Y1+12 FONT_ADDR_o={0x41, 0}; pixel h_cnt=OSD_X1+8 outputs 465 and pixel h_cnt=OSD_X1+9 outputs dimmed colour.
REQ-041 HBLANK_i=1 with RGB_i=0x7FFF -> outputs 0 after 3 cycles; h_cnt=0.
REQ-042 Write to the address being read in the same cycle -> old glyph fetched that cycle, new glyph fetched on the next read.
REQ-043 Assert NRST_i mid-window -> outputs 0 immediately (asynchronously); buffer reads back 0x20 at every address.

Source files
------------

// File: rtl/osd_overlay.sv
// Text overlay for the PPU colour stream: a COLS x ROWS character window drawn
// from a 64-entry buffer and an external registered font ROM, with 3-cycle latency.
module osd_overlay #(
    parameter int OSD_X1 = 96,
    parameter int OSD_Y1 = 80,
    parameter int COLS   = 16,
    parameter int ROWS   = 4
) (
    input  logic        CLK_i,
    input  logic        NRST_i,
    input  logic        PIXEL_EN_i,
    input  logic        HBLANK_i,
    input  logic        VBLANK_i,
    input  logic        OSD_EN_i,
    input  logic [14:0] RGB_i,
    input  logic [3:0]  BRIGHTNESS_i,
    input  logic        CHAR_WE_i,
    input  logic [5:0]  CHAR_WADDR_i,
    input  logic [6:0]  CHAR_WDATA_i,
    output logic [10:0] FONT_ADDR_o,
    input  logic [7:0]  FONT_DATA_i,
    output logic [8:0]  RDIG_o,
    output logic [8:0]  GDIG_o,
    output logic [8:0]  BDIG_o
);

    localparam logic [8:0] X_LO = 9'(OSD_X1);
    localparam logic [8:0] X_HI = 9'(OSD_X1 + COLS * 8);
    localparam logic [8:0] Y_LO = 9'(OSD_Y1);
    localparam logic [8:0] Y_HI = 9'(OSD_Y1 + ROWS * 12);
    localparam logic [8:0] FULL = 9'd465;

    function automatic logic [8:0] scale(input logic [4:0] c, input logic [3:0] k);
        return 9'(c) * 9'(k);
    endfunction

    // Raster position and glyph tracking
    logic [8:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [3:0]  glyph_q, glyph_d;
    logic [1:0]  row_q, row_d;
    logic        hb_q, hb_rise_q, vb_q, osd_en_q;
    logic        v_inc;

    // Character buffer
    logic [6:0]  char_q [64];

    // Pipeline
    logic [8:0]  rel_h;
    logic        in_win;
    logic [5:0]  rd_addr;
    logic [10:0] font_addr_q;
    logic [14:0] rgb_q1, rgb_q2;
    logic        blank_q1, blank_q2, win_q1, win_q2;
    logic [2:0]  bit_q1, bit_q2;
    logic        font_bit;
    logic [8:0]  r_d, g_d, b_d, r_q, g_q, b_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin : counters_next
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        glyph_d = glyph_q;
        row_d   = row_q;
        v_inc   = hb_rise_q && !VBLANK_i && (v_cnt_q != 9'h1FF);

        if (HBLANK_i)
            h_cnt_d = '0;
        else if (PIXEL_EN_i && (h_cnt_q != 9'h1FF))
            h_cnt_d = h_cnt_q + 9'd1;

        if (VBLANK_i)
            v_cnt_d = '0;
        else if (v_inc)
            v_cnt_d = v_cnt_q + 9'd1;

        // Glyph line steps with each line inside the window; 12 lines per text row.
        if (v_cnt_q < Y_LO) begin
            glyph_d = '0;
            row_d   = '0;
        end else if (v_inc && (v_cnt_q < Y_HI)) begin
            if (glyph_q == 4'd11) begin
                glyph_d = '0;
                row_d   = row_q + 2'd1;
            end else begin
                glyph_d = glyph_q + 4'd1;
            end
        end
    end

    assign rel_h   = h_cnt_q - X_LO;
    assign in_win  = osd_en_q && (h_cnt_q >= X_LO) && (h_cnt_q < X_HI)
                              && (v_cnt_q >= Y_LO) && (v_cnt_q < Y_HI);
    assign rd_addr = 6'(int'(row_q) * COLS + int'(rel_h[8:3]));

    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            glyph_q     <= '0;
            row_q       <= '0;
            hb_q        <= 1'b0;
            hb_rise_q   <= 1'b0;
            vb_q        <= 1'b0;
            osd_en_q    <= 1'b0;
            font_addr_q <= '0;
            rgb_q1      <= '0;
            rgb_q2      <= '0;
            blank_q1    <= 1'b0;
            blank_q2    <= 1'b0;
            win_q1      <= 1'b0;
            win_q2      <= 1'b0;
            bit_q1      <= '0;
            bit_q2      <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            glyph_q   <= glyph_d;
            row_q     <= row_d;
            hb_q      <= HBLANK_i;
            hb_rise_q <= HBLANK_i && !hb_q;
            vb_q      <= VBLANK_i;
            if (VBLANK_i && !vb_q)
                osd_en_q <= OSD_EN_i;

            // NOTE: the buffer is read before this edge's write lands, so a same-cycle write returns the old code.
            font_addr_q <= {char_q[rd_addr], glyph_q};
            rgb_q1      <= RGB_i;
            blank_q1    <= HBLANK_i || VBLANK_i;
            win_q1      <= in_win;
            bit_q1      <= rel_h[2:0];

            rgb_q2      <= rgb_q1;
            blank_q2    <= blank_q1;
            win_q2      <= win_q1;
            bit_q2      <= bit_q1;

            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    // NOTE: the buffer is a register file, so reset can load the space code into every entry.
    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            for (int i = 0; i < 64; i++)
                char_q[i] <= 7'h20;
        end else if (CHAR_WE_i) begin
            char_q[CHAR_WADDR_i] <= CHAR_WDATA_i;
        end
    end

    // Font bit 7 is the leftmost pixel of the cell.
    always_comb begin : mix
        font_bit = FONT_DATA_i[~bit_q2];
        r_d = scale(rgb_q2[4:0],   BRIGHTNESS_i);
        g_d = scale(rgb_q2[9:5],   BRIGHTNESS_i);
        b_d = scale(rgb_q2[14:10], BRIGHTNESS_i);
        if (blank_q2) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end else if (win_q2 && font_bit) begin
            r_d = FULL;
            g_d = FULL;
            b_d = FULL;
        end else if (win_q2) begin
            r_d = scale(rgb_q2[4:0]   >> 1, BRIGHTNESS_i);
            g_d = scale(rgb_q2[9:5]   >> 1, BRIGHTNESS_i);
            b_d = scale(rgb_q2[14:10] >> 1, BRIGHTNESS_i);
        end
    end

    assign FONT_ADDR_o = font_addr_q;
    assign RDIG_o      = r_q;
    assign GDIG_o      = g_q;
    assign BDIG_o      = b_q;

endmodule

// File: tb/tb_osd_overlay.sv
// Random raster stimulus against a pixel-level reference of the overlay; a monitor
// pops expected pixels from a scoreboard queue as they leave the DUT pipeline.
module tb_osd_overlay;

    localparam int X1    = 8;
    localparam int Y1    = 4;
    localparam int COLS  = 16;
    localparam int ROWS  = 4;
    localparam int NPIX  = X1 + COLS * 8 + 4;
    localparam int NLINE = Y1 + ROWS * 12 + 1;

    logic        clk;
    logic        NRST_i;
    logic        PIXEL_EN_i, HBLANK_i, VBLANK_i, OSD_EN_i;
    logic [14:0] RGB_i;
    logic [3:0]  BRIGHTNESS_i;
    logic        CHAR_WE_i;
    logic [5:0]  CHAR_WADDR_i;
    logic [6:0]  CHAR_WDATA_i;
    logic [10:0] FONT_ADDR_o;
    logic [7:0]  FONT_DATA_i;
    logic [8:0]  RDIG_o, GDIG_o, BDIG_o;

    osd_overlay #(.OSD_X1(X1), .OSD_Y1(Y1), .COLS(COLS), .ROWS(ROWS)) dut (
        .CLK_i        (clk),
        .NRST_i       (NRST_i),
        .PIXEL_EN_i   (PIXEL_EN_i),
        .HBLANK_i     (HBLANK_i),
        .VBLANK_i     (VBLANK_i),
        .OSD_EN_i     (OSD_EN_i),
        .RGB_i        (RGB_i),
        .BRIGHTNESS_i (BRIGHTNESS_i),
        .CHAR_WE_i    (CHAR_WE_i),
        .CHAR_WADDR_i (CHAR_WADDR_i),
        .CHAR_WDATA_i (CHAR_WDATA_i),
        .FONT_ADDR_o  (FONT_ADDR_o),
        .FONT_DATA_i  (FONT_DATA_i),
        .RDIG_o       (RDIG_o),
        .GDIG_o       (GDIG_o),
        .BDIG_o       (BDIG_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered font ROM, one cycle of latency.
    logic [7:0] rom [2048];
    always @(posedge clk) FONT_DATA_i <= rom[FONT_ADDR_o];

    typedef struct {
        int r, g, b;
        bit chk_addr;
        int addr;
    } exp_t;

    exp_t exp_q[$];
    int   addr_hist[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference state
    int         hcount, vcount, phase;
    bit         osd_lat, prev_vb, prev_hb;
    logic [6:0] shadow [64];
    bit         rand_wr, force_white, pw_valid;
    logic [3:0] bri;
    logic [5:0] pw_addr;
    logic [6:0] pw_data;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hcount  = 0;
        vcount  = 0;
        osd_lat = 0;
        prev_vb = 0;
        prev_hb = 0;
        for (int i = 0; i < 64; i++) shadow[i] = 7'h20;
        exp_q.delete();
    endtask

    // One clock of raster stimulus plus the expected pixel it should produce.
    task automatic drive_cycle(input bit hb, input bit vb);
        exp_t       e;
        bit         geo;
        int         rel, idx, line, code, r, g, b, k;
        logic [7:0] fb;
        @(posedge clk);
        #1;
        HBLANK_i     = hb;
        VBLANK_i     = vb;
        PIXEL_EN_i   = (phase == 0);
        phase        = (phase + 1) % 4;
        RGB_i        = force_white ? 15'h7FFF : 15'($urandom);
        BRIGHTNESS_i = bri;
        CHAR_WE_i    = 1'b0;

        if (vb && !prev_vb) osd_lat = OSD_EN_i;
        prev_vb = vb;

        rel  = hcount - X1;
        geo  = !hb && !vb && hcount >= X1 && hcount < X1 + COLS * 8
                          && vcount >= Y1 && vcount < Y1 + ROWS * 12;
        idx  = geo ? ((vcount - Y1) / 12) * COLS + rel / 8 : 0;
        line = geo ? (vcount - Y1) % 12 : 0;
        code = shadow[idx];

        if (pw_valid) begin
            CHAR_WE_i    = 1'b1;
            CHAR_WADDR_i = pw_addr;
            CHAR_WDATA_i = pw_data;
            pw_valid     = 0;
        end else if (rand_wr && $urandom_range(0, 15) == 0) begin
            CHAR_WE_i = 1'b1;
            if (geo && idx != 17 && $urandom_range(0, 1) == 1)
                CHAR_WADDR_i = 6'(idx);
            else begin
                CHAR_WADDR_i = 6'($urandom_range(0, 63));
                if (CHAR_WADDR_i == 6'd17) CHAR_WADDR_i = 6'd18;
            end
            CHAR_WDATA_i = 7'($urandom);
        end

        r = int'(RGB_i[4:0]);
        g = int'(RGB_i[9:5]);
        b = int'(RGB_i[14:10]);
        k = int'(bri);
        if (hb || vb) begin
            e.r = 0; e.g = 0; e.b = 0;
        end else if (osd_lat && geo) begin
            fb = rom[code * 16 + line];
            if (fb[7 - rel % 8]) begin
                e.r = 465; e.g = 465; e.b = 465;
            end else begin
                e.r = (r / 2) * k; e.g = (g / 2) * k; e.b = (b / 2) * k;
            end
        end else begin
            e.r = r * k; e.g = g * k; e.b = b * k;
        end
        e.chk_addr = geo;
        e.addr     = code * 16 + line;
        if (NRST_i) exp_q.push_back(e);

        if (CHAR_WE_i) shadow[CHAR_WADDR_i] = CHAR_WDATA_i;
        if (hb) begin
            if (!prev_hb && !vb) vcount++;
            hcount = 0;
        end else if (PIXEL_EN_i && hcount < 511) begin
            hcount++;
        end
        if (vb) vcount = 0;
        prev_hb = hb;
    endtask

    task automatic do_mid_reset();
        @(negedge clk);
        #2 NRST_i = 1'b0;
        #1;
        check("async_rst_rdig", int'(RDIG_o), 0);
        check("async_rst_gdig", int'(GDIG_o), 0);
        check("async_rst_bdig", int'(BDIG_o), 0);
        check("async_rst_font_addr", int'(FONT_ADDR_o), 0);
        model_reset();
        HBLANK_i  = 1'b0;
        VBLANK_i  = 1'b0;
        CHAR_WE_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 NRST_i = 1'b1;
    endtask

    task automatic run_line(input int npix, input bit vb, input int rst_px);
        for (int i = 0; i < npix * 4; i++) begin
            drive_cycle(1'b0, vb);
            if (i == rst_px * 4) begin
                do_mid_reset();
                return;
            end
        end
        for (int i = 0; i < 8; i++) begin
            // Brightness only changes once in-flight active pixels have drained.
            if (i == 4) bri = force_white ? 4'd15 : 4'($urandom);
            drive_cycle(1'b1, vb);
        end
    endtask

    task automatic run_frame(input int lines, input int npix, input bit osd_next);
        OSD_EN_i = osd_next;
        for (int i = 0; i < 2; i++) run_line(10, 1'b1, -1);
        for (int i = 0; i < lines; i++) begin
            OSD_EN_i = 1'($urandom);
            run_line(npix, 1'b0, -1);
        end
    endtask

    // Monitor: each cycle retire the pixel that entered three cycles earlier.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!NRST_i) begin
                addr_hist.delete();
            end else begin
                addr_hist.push_back(int'(FONT_ADDR_o));
                if (addr_hist.size() > 3) void'(addr_hist.pop_front());
                if (exp_q.size() >= 4) begin
                    e = exp_q.pop_front();
                    check("rdig", int'(RDIG_o), e.r);
                    check("gdig", int'(GDIG_o), e.g);
                    check("bdig", int'(BDIG_o), e.b);
                    if (e.chk_addr && addr_hist.size() == 3)
                        check("font_addr", addr_hist[0], e.addr);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) rom[16 * 'h20 + i] = 8'h00;
        rom[16 * 'h41] = 8'h80;

        NRST_i       = 1'b0;
        PIXEL_EN_i   = 1'b0;
        HBLANK_i     = 1'b0;
        VBLANK_i     = 1'b0;
        OSD_EN_i     = 1'b0;
        RGB_i        = 15'h7FFF;
        BRIGHTNESS_i = 4'd15;
        CHAR_WE_i    = 1'b0;
        CHAR_WADDR_i = '0;
        CHAR_WDATA_i = '0;
        phase        = 0;
        bri          = 4'd15;
        force_white  = 1;
        rand_wr      = 0;
        pw_valid     = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_rdig", int'(RDIG_o), 0);
        check("reset_gdig", int'(GDIG_o), 0);
        check("reset_bdig", int'(BDIG_o), 0);
        check("reset_font_addr", int'(FONT_ADDR_o), 0);
        @(negedge clk);
        #2 NRST_i = 1'b1;

        // Overlay off, white input at full brightness.
        pw_addr  = 6'd17;
        pw_data  = 7'h41;
        pw_valid = 1;
        run_frame(3, 40, 1'b0);

        // Overlay on with random characters, including same-cycle rewrites.
        force_white = 0;
        rand_wr     = 1;
        run_frame(NLINE, NPIX, 1'b1);

        // Reset asserted in the middle of the text window.
        OSD_EN_i = 1'b1;
        for (int i = 0; i < 2; i++) run_line(10, 1'b1, -1);
        for (int i = 0; i < Y1 + 14; i++) run_line(NPIX, 1'b0, -1);
        run_line(NPIX, 1'b0, X1 + 20);
        rand_wr = 0;
        for (int i = 0; i < 3; i++) run_line(NPIX, 1'b0, -1);

        // First full frame after reset: every cell must read back as a space.
        run_frame(NLINE, NPIX, 1'b1);

        repeat (6) drive_cycle(1'b1, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
